mac_array_ctrl: RTL and testbench

Sequencer for a `row` × `col` weight-stationary MAC array built from stacked MAC rows. On a start command it streams `col` kernel words from the input buffer into the array under the load instruction, then streams `num_vec` activation words under the execute instruction, then drains the array and pulses `done`. Per-row instruction and data buses are skewed diagonally so that each row sees its stream one cycle after the row above. It sits between the L0 input buffer and the west edge of the array.

---
 rtl/mac_ctrl_pkg.sv | 26 ++
 rtl/mac_array_ctrl_if.sv | 14 +
 rtl/skew_pipe.sv | 37 +++
 rtl/mac_array_ctrl.sv | 132 +++++++++++++
 tb/tb_mac_array_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_ctrl_pkg.sv
// Shared definitions for the MAC array sequencer: FSM state encoding and the
// two-bit per-row instruction codes driven onto the west edge of the array.
package mac_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    GAP   = 3'd2,
    EXEC  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam logic [1:0] INST_NOP  = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  function automatic logic [1:0] issue_inst(input state_e s);
    case (s)
      LOAD:    return INST_LOAD;
      EXEC:    return INST_EXEC;
      default: return INST_NOP;
    endcase
  endfunction

endpackage

// File: rtl/mac_array_ctrl_if.sv
// Read port between the sequencer and the L0 input buffer; data returns one
// cycle after the read strobe.
interface mac_array_ctrl_if #(
  parameter int bw      = 4,
  parameter int row     = 8,
  parameter int addr_bw = 8
);
  logic                 mem_rd_en;
  logic [addr_bw-1:0]   mem_addr;
  logic [bw*row-1:0]    mem_dout;

  modport master (output mem_rd_en, output mem_addr, input mem_dout);
  modport slave  (input mem_rd_en, input mem_addr, output mem_dout);
endinterface

// File: rtl/skew_pipe.sv
// Fixed-depth delay line with asynchronous active-low clear; used to skew
// each row's data/instruction stream diagonally across the array.
module skew_pipe #(
  parameter int width = 6,
  parameter int depth = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout
);

  logic [width-1:0] pipe_q [depth];
  logic [width-1:0] pipe_d [depth];

  always_comb begin
    pipe_d[0] = din;
    for (int i = 1; i < depth; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < depth; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign dout = pipe_q[depth-1];

endmodule

// File: rtl/mac_array_ctrl.sv
// Sequencer for a weight-stationary MAC array: loads col kernel words, streams
// num_vec activations, drains, then pulses done. Row streams are skewed by row.
module mac_array_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int bw      = 4,
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [addr_bw-1:0]    num_vec,
  mac_array_ctrl_if.master      mem,
  output logic [bw*row-1:0]     in_w,
  output logic [2*row-1:0]      inst_w,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = addr_bw + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [addr_bw-1:0] nv_q, nv_d;
  logic [addr_bw-1:0] addr_q, addr_d;
  logic [1:0]         inst_q, inst_d;
  logic               rd_vld_q, rd_vld_d;
  logic               rd_en;
  logic               term;

  assign rd_en = (state_q == LOAD) || (state_q == EXEC);
  assign term  = (cnt_q == '0);

  // Each state's counter is loaded with (duration - 1) on entry and the
  // transition fires when it reaches zero.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nv_d     = nv_q;
    addr_d   = addr_q;
    inst_d   = issue_inst(state_q);
    rd_vld_d = rd_en;
    if (state_q == IDLE) begin
      if (start && (num_vec != '0)) begin
        state_d = LOAD;
        cnt_d   = CNT_W'(col - 1);
        nv_d    = num_vec;
        addr_d  = '0;
      end
    end else if (!term) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (rd_en) begin
        addr_d = addr_q + addr_bw'(1);
      end
    end else begin
      case (state_q)
        LOAD: begin
          state_d = GAP;
          cnt_d   = '0;
        end
        GAP: begin
          state_d = EXEC;
          cnt_d   = CNT_W'(nv_q) - CNT_W'(1);
          addr_d  = addr_bw'(col);
        end
        EXEC: begin
          state_d = DRAIN;
          cnt_d   = CNT_W'(row + col - 1);
        end
        DRAIN: begin
          state_d = DONE;
          cnt_d   = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      nv_q     <= '0;
      addr_q   <= '0;
      inst_q   <= INST_NOP;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      nv_q     <= nv_d;
      addr_q   <= addr_d;
      inst_q   <= inst_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  assign mem.mem_rd_en = rd_en;
  assign mem.mem_addr  = addr_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);

  // Align stage: inst_q meets the buffer data it was issued with. Data lanes
  // are masked outside read-return cycles so idle rows stay at zero.
  for (genvar r = 0; r < row; r++) begin : g_row
    logic [bw-1:0]   lane;
    logic [bw+1:0]   stage_in;
    logic [bw+1:0]   stage_out;

    assign lane     = rd_vld_q ? mem.mem_dout[bw*r +: bw] : '0;
    assign stage_in = {inst_q, lane};

    if (r == 0) begin : g_direct
      assign stage_out = stage_in;
    end else begin : g_skew
      skew_pipe #(
        .width (bw + 2),
        .depth (r)
      ) u_skew (
        .clk   (clk),
        .reset (reset),
        .din   (stage_in),
        .dout  (stage_out)
      );
    end

    assign inst_w[2*r +: 2] = stage_out[bw+1:bw];
    assign in_w[bw*r +: bw] = stage_out[bw-1:0];
  end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Scoreboard bench for mac_array_ctrl: per-cycle expected output records are
// queued at each accepted start and compared on every falling clock edge.
module tb_mac_array_ctrl;

  localparam int BW  = 4;
  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int AW  = 8;
  localparam int AW2 = 4;

  typedef struct {
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [AW-1:0]     addr;
    logic [2*ROW-1:0]  inst;
    logic [BW*ROW-1:0] inw;
  } exp_t;

  logic               clk;
  logic               reset;
  logic               start;
  logic [AW-1:0]      num_vec;
  logic [BW*ROW-1:0]  in_w;
  logic [2*ROW-1:0]   inst_w;
  logic               busy;
  logic               done;

  logic               start2;
  logic [AW2-1:0]     num_vec2;
  logic [BW*ROW-1:0]  in_w2;
  logic [2*ROW-1:0]   inst_w2;
  logic               busy2;
  logic               done2;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t exp_q[$];
  int   a2_q[$];

  mac_array_ctrl_if #(.bw(BW), .row(ROW), .addr_bw(AW))  mem_if ();
  mac_array_ctrl_if #(.bw(BW), .row(ROW), .addr_bw(AW2)) mem2_if ();

  mac_array_ctrl #(.bw(BW), .row(ROW), .col(COL), .addr_bw(AW)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .num_vec (num_vec),
    .mem     (mem_if),
    .in_w    (in_w),
    .inst_w  (inst_w),
    .busy    (busy),
    .done    (done)
  );

  mac_array_ctrl #(.bw(BW), .row(ROW), .col(COL), .addr_bw(AW2)) dut_wrap (
    .clk     (clk),
    .reset   (reset),
    .start   (start2),
    .num_vec (num_vec2),
    .mem     (mem2_if),
    .in_w    (in_w2),
    .inst_w  (inst_w2),
    .busy    (busy2),
    .done    (done2)
  );

  assign mem2_if.mem_dout = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer model: lane r of word a holds (a + r), returned one cycle later.
  always @(posedge clk) begin
    if (mem_if.mem_rd_en) begin
      for (int r = 0; r < ROW; r++) begin
        mem_if.mem_dout[BW*r +: BW] <= BW'(int'(mem_if.mem_addr) + r);
      end
    end
  end

  initial mem_if.mem_dout = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, want %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic exp_t idle_rec();
    exp_t e;
    e.busy  = 1'b0;
    e.done  = 1'b0;
    e.rd_en = 1'b0;
    e.addr  = '0;
    e.inst  = '0;
    e.inw   = '0;
    return e;
  endfunction

  // Expected outputs at cycle t (1-based) after the start-sampling edge.
  function automatic exp_t mk_rec(int t, int nv);
    exp_t e;
    int lat;
    int a;
    int ad;
    lat     = 2*COL + ROW + 2 + nv;
    e       = idle_rec();
    e.busy  = 1'b1;
    e.done  = (t == lat);
    if (t >= 1 && t <= COL) begin
      e.rd_en = 1'b1;
      e.addr  = AW'(t - 1);
    end else if (t >= COL + 2 && t <= COL + 1 + nv) begin
      e.rd_en = 1'b1;
      e.addr  = AW'(COL + t - COL - 2);
    end
    for (int r = 0; r < ROW; r++) begin
      a = t - r;
      if (a >= 2 && a <= COL + 1) begin
        ad = a - 2;
        e.inst[2*r +: 2]  = 2'b01;
        e.inw[BW*r +: BW] = BW'(ad + r);
      end else if (a >= COL + 3 && a <= COL + 2 + nv) begin
        ad = (COL + a - COL - 3) % (1 << AW);
        e.inst[2*r +: 2]  = 2'b10;
        e.inw[BW*r +: BW] = BW'(ad + r);
      end
    end
    return e;
  endfunction

  task automatic push_run(input int nv);
    for (int t = 1; t <= 2*COL + ROW + 2 + nv; t++) begin
      exp_q.push_back(mk_rec(t, nv));
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = idle_rec();
    check("busy",   64'(busy),             64'(e.busy));
    check("done",   64'(done),             64'(e.done));
    check("rd_en",  64'(mem_if.mem_rd_en), 64'(e.rd_en));
    if (e.rd_en) check("addr", 64'(mem_if.mem_addr), 64'(e.addr));
    check("inst_w", 64'(inst_w),           64'(e.inst));
    check("in_w",   64'(in_w),             64'(e.inw));
  end

  always @(negedge clk) begin
    if (mem2_if.mem_rd_en) begin
      if (a2_q.size() > 0) check("wrap_addr", 64'(mem2_if.mem_addr), 64'(a2_q.pop_front()));
      else                 check("wrap_extra_rd", 64'(1), 64'(0));
    end
  end

  task automatic do_run(input int nv, input bit poke);
    int lat;
    int n;
    lat     = 2*COL + ROW + 2 + nv;
    start   = 1'b1;
    num_vec = AW'(nv);
    @(posedge clk);
    #1 start = 1'b0;
    push_run(nv);
    n = 0;
    while (!done && n < lat + 20) begin
      @(negedge clk);
      n++;
      if (poke) start = (n == COL + 3);
    end
    start = 1'b0;
    check("latency", 64'(n), 64'(lat));
  endtask

  initial begin
    int n;
    reset    = 1'b0;
    start    = 1'b0;
    num_vec  = '0;
    start2   = 1'b0;
    num_vec2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  64'(busy),             64'(0));
    check("rst_done",  64'(done),             64'(0));
    check("rst_rd",    64'(mem_if.mem_rd_en), 64'(0));
    check("rst_addr",  64'(mem_if.mem_addr),  64'(0));
    check("rst_inst",  64'(inst_w),           64'(0));
    check("rst_inw",   64'(in_w),             64'(0));
    reset = 1'b1;
    @(posedge clk);
    #1;

    do_run(4, 1'b0);
    @(posedge clk);
    #1 do_run(3, 1'b0);

    @(posedge clk);
    #1;
    start   = 1'b1;
    num_vec = '0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("nv0_busy", 64'(busy), 64'(0));

    do_run(4, 1'b1);

    @(posedge clk);
    #1;
    start   = 1'b1;
    num_vec = AW'(4);
    @(posedge clk);
    #1 start = 1'b0;
    push_run(4);
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_busy", 64'(busy),             64'(0));
    check("mid_rst_done", 64'(done),             64'(0));
    check("mid_rst_rd",   64'(mem_if.mem_rd_en), 64'(0));
    check("mid_rst_addr", 64'(mem_if.mem_addr),  64'(0));
    check("mid_rst_inst", 64'(inst_w),           64'(0));
    check("mid_rst_inw",  64'(in_w),             64'(0));
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    do_run(1, 1'b0);

    @(posedge clk);
    #1;
    start2   = 1'b1;
    num_vec2 = AW2'(10);
    @(posedge clk);
    #1 start2 = 1'b0;
    for (int k = 0; k < COL; k++) a2_q.push_back(k);
    for (int k = 0; k < 10; k++)  a2_q.push_back((COL + k) % (1 << AW2));
    n = 0;
    while (!done2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wrap_latency", 64'(n), 64'(2*COL + ROW + 2 + 10));
    check("wrap_left",    64'(a2_q.size()), 64'(0));
    check("sb_left",      64'(exp_q.size()), 64'(0));

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
